// File: rtl/pc_fetch_pkg.sv
// Shared fetch definitions: FSM state encodings and the default reset PC.
// Also hosts the alignment helper used when PC_ALIGN_CHECK_EN is defined.
package pc_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_VALID = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HALT  = 3'd4
    } fetch_state_e;

    // A PC is word-aligned when its two low bits are zero.
    function automatic logic pc_misaligned(input logic [31:0] pc);
        return (pc[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/pc_fetch.sv
// Fetch stage: holds the PC, fetches over imem req/ack, hands the instruction to decode.
// Optional macro PC_ALIGN_CHECK_EN adds misalign_o and a HALT state on misaligned PC loads.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rstn,
    output logic [ADDR_W-1:0] pc_o,
    input  logic [ADDR_W-1:0] npc_i,
    output logic [31:0]       inst_o,
    output logic              inst_valid_o,
    input  logic              id_ready_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_pc_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [31:0]       imem_rdata_i
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic              misalign_o
`endif
);

    fetch_state_e      state_r;
    fetch_state_e      state_nx_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_nx_s;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       inst_r;
    logic              inst_valid_r;
    logic              req_r;
    logic              pc_ld_s;
    logic              capture_s;
`ifdef PC_ALIGN_CHECK_EN
    logic              misalign_r;
    logic              misalign_nx_s;
`endif

    // Next-state and next-PC selection; flush outranks every other event.
    always_comb begin
        state_nx_s = state_r;
        pc_nx_s    = pc_r;
        pc_ld_s    = 1'b0;
        capture_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (flush_i) begin
                    pc_nx_s = flush_pc_i;
                    pc_ld_s = 1'b1;
                end else begin
                    pc_nx_s = pc_r;
                end
                state_nx_s = ST_FETCH;
            end
            ST_FETCH: begin
                if (flush_i) begin
                    pc_nx_s    = flush_pc_i;
                    pc_ld_s    = 1'b1;
                    // An outstanding request must still be drained to its ack.
                    state_nx_s = imem_ack_i ? ST_FETCH : ST_DRAIN;
                end else if (imem_ack_i) begin
                    capture_s  = 1'b1;
                    state_nx_s = ST_VALID;
                end else begin
                    state_nx_s = ST_FETCH;
                end
            end
            ST_VALID: begin
                if (flush_i) begin
                    pc_nx_s    = flush_pc_i;
                    pc_ld_s    = 1'b1;
                    state_nx_s = ST_FETCH;
                end else if (id_ready_i) begin
                    pc_nx_s    = npc_i;
                    pc_ld_s    = 1'b1;
                    state_nx_s = ST_FETCH;
                end else begin
                    state_nx_s = ST_VALID;
                end
            end
            ST_DRAIN: begin
                if (flush_i) begin
                    pc_nx_s = flush_pc_i;
                    pc_ld_s = 1'b1;
                end else begin
                    pc_nx_s = pc_r;
                end
                state_nx_s = imem_ack_i ? ST_FETCH : ST_DRAIN;
            end
            ST_HALT: begin
                if (flush_i) begin
                    pc_nx_s    = flush_pc_i;
                    pc_ld_s    = 1'b1;
                    state_nx_s = ST_FETCH;
                end else begin
                    state_nx_s = ST_HALT;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
`ifdef PC_ALIGN_CHECK_EN
        misalign_nx_s = misalign_r;
        if (pc_ld_s) begin
            misalign_nx_s = pc_misaligned(pc_nx_s);
        end else begin
            misalign_nx_s = misalign_r;
        end
        // A pending drain finishes first; only a new fetch is diverted to HALT.
        if (misalign_nx_s && (state_nx_s == ST_FETCH)) begin
            state_nx_s = ST_HALT;
        end else begin
            state_nx_s = state_nx_s;
        end
`endif
    end

    // State, PC, address latch and registered handshake outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r      <= ST_IDLE;
            pc_r         <= RESET_PC;
            addr_r       <= RESET_PC;
            inst_r       <= 32'h0000_0000;
            inst_valid_r <= 1'b0;
            req_r        <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            pc_r         <= pc_nx_s;
            addr_r       <= (state_nx_s == ST_DRAIN) ? addr_r : pc_nx_s;
            inst_r       <= capture_s ? imem_rdata_i : inst_r;
            inst_valid_r <= (state_nx_s == ST_VALID);
            req_r        <= (state_nx_s == ST_FETCH) || (state_nx_s == ST_DRAIN);
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    // Sticky misalignment flag, cleared only by an aligned PC load.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            misalign_r <= 1'b0;
        end else begin
            misalign_r <= misalign_nx_s;
        end
    end

    assign misalign_o = misalign_r;
`endif

    assign pc_o         = pc_r;
    assign imem_addr_o  = addr_r;
    assign inst_o       = inst_r;
    assign inst_valid_o = inst_valid_r;
    assign imem_req_o   = req_r;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch with a wait-configurable instruction memory responder.
module tb_pc_fetch;

    logic        clk;
    logic        rstn;
    logic [31:0] pc_o;
    logic [31:0] npc_i;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        id_ready_i;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
`ifdef PC_ALIGN_CHECK_EN
    logic        misalign_o;
`endif

    int errors = 0;
    int checks = 0;
    int wait_cfg = 0;
    int wcnt = 0;

    pc_fetch dut (
        .clk          (clk),
        .rstn         (rstn),
        .pc_o         (pc_o),
        .npc_i        (npc_i),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o),
        .id_ready_i   (id_ready_i),
        .flush_i      (flush_i),
        .flush_pc_i   (flush_pc_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_rdata_i (imem_rdata_i)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .misalign_o   (misalign_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_3000) return 32'h2008_0005;
        else return a ^ 32'hDEAD_0000;
    endfunction

    // Memory responder: acks after wait_cfg idle cycles of a held request.
    always @(negedge clk) begin
        if (imem_req_o === 1'b1) begin
            if (wcnt >= wait_cfg) begin
                imem_ack_i   = 1'b1;
                imem_rdata_i = mem_word(imem_addr_o);
                wcnt         = 0;
            end else begin
                imem_ack_i   = 1'b0;
                imem_rdata_i = 32'h0000_0000;
                wcnt         = wcnt + 1;
            end
        end else begin
            imem_ack_i   = 1'b0;
            imem_rdata_i = 32'h0000_0000;
            wcnt         = 0;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        tick();
        check_val("rst_pc", pc_o, 32'h0000_3000);
        check_val("rst_valid", {31'd0, inst_valid_o}, 32'd0);
        check_val("rst_req", {31'd0, imem_req_o}, 32'd0);
        check_val("rst_inst", inst_o, 32'h0000_0000);
`ifdef PC_ALIGN_CHECK_EN
        check_val("rst_misalign", {31'd0, misalign_o}, 32'd0);
`endif
        rstn = 1'b1;
        tick();
        check_val("first_req", {31'd0, imem_req_o}, 32'd1);
        check_val("first_addr", imem_addr_o, 32'h0000_3000);
        tick();
        check_val("first_valid", {31'd0, inst_valid_o}, 32'd1);
        check_val("first_inst", inst_o, 32'h2008_0005);
        check_val("first_req_drop", {31'd0, imem_req_o}, 32'd0);
    endtask

    // Consume the instruction in VALID with the given next PC; expect a fetch there.
    task automatic consume(input logic [31:0] npc, input string tag);
        npc_i      = npc;
        id_ready_i = 1'b1;
        tick();
        check_val({tag, "_pc"}, pc_o, npc);
        check_val({tag, "_addr"}, imem_addr_o, npc);
        check_val({tag, "_req"}, {31'd0, imem_req_o}, 32'd1);
        check_val({tag, "_nvalid"}, {31'd0, inst_valid_o}, 32'd0);
        id_ready_i = 1'b0;
    endtask

    initial begin
        rstn       = 1'b0;
        npc_i      = 32'h0;
        id_ready_i = 1'b0;
        flush_i    = 1'b0;
        flush_pc_i = 32'h0;
        do_reset();

        // Backpressure: everything stays put while decode stalls.
        for (int i = 0; i < 5; i++) begin
            npc_i = 32'h0000_7000 + 32'(i) * 32'h10;
            tick();
            check_val("bp_valid", {31'd0, inst_valid_o}, 32'd1);
            check_val("bp_inst", inst_o, 32'h2008_0005);
            check_val("bp_pc", pc_o, 32'h0000_3000);
            check_val("bp_req", {31'd0, imem_req_o}, 32'd0);
        end

        // Sequential flow with zero-wait memory: a new request every 2 cycles.
        for (int i = 1; i < 3; i++) begin
            logic [31:0] a;
            a = 32'h0000_3000 + 32'(i) * 32'd4;
            consume(a, "seq");
            tick();
            check_val("seq_valid", {31'd0, inst_valid_o}, 32'd1);
            check_val("seq_inst", inst_o, mem_word(a));
        end

        // Flush during a 3-wait fetch of 0x3004.
        do_reset();
        wait_cfg = 3;
        consume(32'h0000_3004, "slow");
        flush_i    = 1'b1;
        flush_pc_i = 32'h0000_4180;
        for (int i = 0; i < 3; i++) begin
            tick();
            flush_i = 1'b0;
            check_val("drain_addr", imem_addr_o, 32'h0000_3004);
            check_val("drain_req", {31'd0, imem_req_o}, 32'd1);
            check_val("drain_nvalid", {31'd0, inst_valid_o}, 32'd0);
            check_val("drain_pc", pc_o, 32'h0000_4180);
        end
        tick();
        check_val("redir_addr", imem_addr_o, 32'h0000_4180);
        check_val("redir_req", {31'd0, imem_req_o}, 32'd1);
        check_val("redir_nvalid", {31'd0, inst_valid_o}, 32'd0);
        wait_cfg = 0;
        tick();
        check_val("redir_valid", {31'd0, inst_valid_o}, 32'd1);
        check_val("redir_inst", inst_o, mem_word(32'h0000_4180));

        // Flush coincident with consume: flush target wins over npc.
        npc_i      = 32'h0000_4184;
        id_ready_i = 1'b1;
        flush_i    = 1'b1;
        flush_pc_i = 32'h0000_5000;
        tick();
        id_ready_i = 1'b0;
        flush_i    = 1'b0;
        check_val("fr_pc", pc_o, 32'h0000_5000);
        check_val("fr_addr", imem_addr_o, 32'h0000_5000);
        check_val("fr_nvalid", {31'd0, inst_valid_o}, 32'd0);
        tick();
        check_val("fr_inst", inst_o, mem_word(32'h0000_5000));

        // Flush in FETCH with a same-cycle ack: data dropped, refetch at target.
        consume(32'h0000_5004, "fa");
        flush_i    = 1'b1;
        flush_pc_i = 32'h0000_6000;
        tick();
        flush_i = 1'b0;
        check_val("fa_addr", imem_addr_o, 32'h0000_6000);
        check_val("fa_req", {31'd0, imem_req_o}, 32'd1);
        check_val("fa_nvalid", {31'd0, inst_valid_o}, 32'd0);
        tick();
        check_val("fa_inst", inst_o, mem_word(32'h0000_6000));

`ifdef PC_ALIGN_CHECK_EN
        // Misaligned next PC halts fetch until an aligned flush.
        npc_i      = 32'h0000_3006;
        id_ready_i = 1'b1;
        tick();
        id_ready_i = 1'b0;
        check_val("mis_flag", {31'd0, misalign_o}, 32'd1);
        check_val("mis_req", {31'd0, imem_req_o}, 32'd0);
        tick();
        check_val("mis_req2", {31'd0, imem_req_o}, 32'd0);
        check_val("mis_nvalid", {31'd0, inst_valid_o}, 32'd0);
        flush_i    = 1'b1;
        flush_pc_i = 32'h0000_3000;
        tick();
        flush_i = 1'b0;
        check_val("mis_clear", {31'd0, misalign_o}, 32'd0);
        check_val("mis_resume", {31'd0, imem_req_o}, 32'd1);
        check_val("mis_addr", imem_addr_o, 32'h0000_3000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
- Fetch-side counterpart to the next-PC logic. Holds the architectural PC and drives it to the NPC computation.
- Fetches the instruction at PC from instruction memory over a req/ack handshake and presents it to decode with valid/ready.
- Loads the next-PC result back into PC when decode consumes the instruction. Supports a redirect/flush port for exceptions and late redirects.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset; first fetch address.
ADDR_W, 32, PC and address width; only 32 is supported.

Ports:
clk  input  1  system clock, rising edge.
rstn  input  1  asynchronous active-low reset.
pc_o  output 32  current PC; feeds the NPC PC input and decode.
npc_i  input  32  next PC from NPC logic, computed from pc_o.
inst_o  output 32  fetched instruction, valid when inst_valid_o=1.
inst_valid_o  output 1  instruction on inst_o is valid.
id_ready_i  input  1  decode accepts inst_o this cycle.
flush_i  input  1  redirect request; takes priority over all other events.
flush_pc_i  input  32  redirect target, sampled when flush_i=1.
imem_req_o  output 1  instruction memory request.
imem_addr_o  output 32  request address; always equals pc_o.
imem_ack_i  input  1  memory returns data this cycle; ignored unless imem_req_o=1.
imem_rdata_i  input  32  instruction data, valid with imem_ack_i.

Behaviour:
- Reset (async, rstn=0):
  - pc_o=RESET_PC, inst_o=0, inst_valid_o=0, imem_req_o=0, state=IDLE.
  - Release is synchronous to clk.
- State encodings and next-state logic:
  - IDLE: one cycle after reset; go to FETCH.
  - FETCH: imem_req_o=1, imem_addr_o=pc_o.
    - Request, PC and address stay stable until imem_ack_i.
    - On ack: inst_o<=imem_rdata_i, inst_valid_o<=1, go to VALID.
  - VALID: inst_valid_o=1, imem_req_o=0; inst_o and pc_o are stable.
    - On id_ready_i=1: pc_o<=npc_i, inst_valid_o<=0, go to FETCH.
    - Fetch-to-fetch minimum is 2 cycles with a zero-wait memory.
  - DRAIN: imem_req_o held at 1 with the old address until imem_ack_i.
    - The returned data is discarded and inst_valid_o stays 0.
    - Then go to FETCH, already at the redirected pc_o.
- Flush (flush_i=1), highest priority:
  - pc_o<=flush_pc_i and inst_valid_o<=0 in every state.
  - FETCH without ack in the same cycle: go to DRAIN. A request is never abandoned mid-handshake.
  - FETCH with ack in the same cycle: discard the data, go to FETCH.
  - VALID or IDLE: go to FETCH. id_ready_i is ignored in that cycle.
  - DRAIN: update pc_o, stay in DRAIN until ack.
  - While in DRAIN, imem_addr_o keeps the outstanding address (internal latch), not pc_o. This is the only exception to imem_addr_o==pc_o.
- Arithmetic: none inside the block. PC+4 and branch/jump arithmetic stay in the NPC logic. npc_i wraps naturally at 2^32.
- imem_ack_i while not requesting is ignored.
- Reset asserted mid-handshake returns to IDLE immediately. The memory must drop any pending response on reset.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- When defined:
  - Adds output misalign_o (1 bit, reset 0).
  - Any PC load (npc_i or flush_pc_i) with bits [1:0]!=0 sets misalign_o=1 and enters a HALT state. In HALT no request is issued and inst_valid_o=0.
  - Only flush_i with an aligned flush_pc_i clears misalign_o and goes to FETCH. A misaligned flush target re-enters HALT.
- When undefined: no port, no check; bits [1:0] are passed through to imem_addr_o unchanged.

Decomposition:
- Shared define file fetch_def.v holds:
  - state encodings: IDLE, FETCH, VALID, DRAIN, HALT;
  - the default RESET_PC.
- It is included alongside the existing control-encoding defines.
- No sub-module; PC register, address latch and FSM form a single module.

Test Plan:
- Reset release with zero-wait memory (ack the cycle after req): first req address 0x00003000; inst 0x20080005 is presented valid in the cycle after ack.
- Backpressure: id_ready_i=0 for 5 cycles in VALID. inst_o, pc_o and inst_valid_o stay stable; no imem_req_o; npc_i changes are ignored.
- Sequential flow: npc_i=pc+4 and id_ready_i always high over 3 instructions. Fetch addresses are 0x3000, 0x3004, 0x3008 with a 2-cycle cadence.
- Flush during a 3-wait-cycle fetch of 0x3004, flush_pc_i=0x00004180:
  - DRAIN keeps address 0x3004 until ack; that data is dropped.
  - The next req is at 0x4180; no valid is seen for 0x3004.
- Flush coincident with id_ready_i in VALID: pc_o becomes flush_pc_i, not npc_i.
- With PC_ALIGN_CHECK_EN: npc_i=0x00003006 on consume sets misalign_o=1, no further req. A flush to 0x3000 resumes fetching.
